// File: rtl/key_filter_multi.sv
// Multi-channel push-button debouncer: 2-flop synchroniser, per-key IDLE/FILTER0/DOWN/FILTER1 FSM,
// press/release/long-press pulses. Define KEY_AUTOREPEAT_EN to re-fire key_long while a key stays held.
module key_filter_multi #(
    parameter int NUM_KEYS      = 4,
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_state,
    output logic                key_any
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILTER0 = 2'd1,
        S_DOWN    = 2'd2,
        S_FILTER1 = 2'd3
    } state_t;

    localparam logic             IDLE_LVL = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES - 1);
`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_MAX  = CNT_W'(REPEAT_CYCLES - 1);
`endif

    // Elaboration guard: every compare value must fit in the counter.
    if ((64'(DEB_CYCLES) > (64'd1 << CNT_W)) || (64'(LONG_CYCLES) > (64'd1 << CNT_W)) ||
        (64'(REPEAT_CYCLES) > (64'd1 << CNT_W))) begin : g_cnt_w_too_narrow
        $error("key_filter_multi: CNT_W too narrow for the configured cycle counts");
    end

    logic [NUM_KEYS-1:0] sync1, sync2;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1 <= {NUM_KEYS{IDLE_LVL}};
            sync2 <= {NUM_KEYS{IDLE_LVL}};
        end else begin
            // NOTE: non-blocking assignments make sync2 take sync1's old value, giving two real flops.
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             long_done;
        logic             press_q, rel_q, long_q, level_q;
        logic             p;

        assign p = (sync2[i] != IDLE_LVL);

        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
                state     <= S_IDLE;
                cnt       <= '0;
                long_done <= 1'b0;
                press_q   <= 1'b0;
                rel_q     <= 1'b0;
                long_q    <= 1'b0;
                level_q   <= 1'b1;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (p) begin
                            state <= S_FILTER0;
                            cnt   <= '0;
                        end
                    end
                    S_FILTER0: begin
                        if (!p) begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end else if (cnt == DEB_MAX) begin
                            state     <= S_DOWN;
                            press_q   <= 1'b1;
                            level_q   <= 1'b0;
                            cnt       <= '0;
                            long_done <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_DOWN: begin
                        if (!p) begin
                            state <= S_FILTER1;
                            cnt   <= '0;
                        end else begin
`ifdef KEY_AUTOREPEAT_EN
                            if (!long_done && cnt == LONG_MAX) begin
                                long_q    <= 1'b1;
                                long_done <= 1'b1;
                                cnt       <= '0;
                            end else if (long_done && cnt == REP_MAX) begin
                                long_q <= 1'b1;
                                cnt    <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
`else
                            // Counter parks at LONG_MAX so a kept long_done can never re-fire.
                            if (cnt == LONG_MAX) begin
                                if (!long_done) begin
                                    long_q    <= 1'b1;
                                    long_done <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
`endif
                        end
                    end
                    S_FILTER1: begin
                        if (p) begin
                            state <= S_DOWN;
                            cnt   <= '0;
                        end else if (cnt == DEB_MAX) begin
                            state   <= S_IDLE;
                            rel_q   <= 1'b1;
                            level_q <= 1'b1;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        cnt       <= '0;
                        long_done <= 1'b0;
                        level_q   <= 1'b1;
                    end
                endcase
            end
        end

        assign key_press[i]   = press_q;
        assign key_release[i] = rel_q;
        assign key_long[i]    = long_q;
        assign key_state[i]   = level_q;
    end

    assign key_any = |(~key_state);

endmodule

// File: tb/tb_key_filter_multi.sv
// Directed bench for key_filter_multi (DEB=4, LONG=20, REPEAT=8), with an ACTIVE_LOW=0 instance alongside.
module tb_key_filter_multi;

    localparam int NK = 4;

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [3:0] EXP_LONG_AT28 = 4'b1000;
    localparam int         EXP_LONG3_CNT = 6;
`else
    localparam logic [3:0] EXP_LONG_AT28 = 4'b0000;
    localparam int         EXP_LONG3_CNT = 1;
`endif

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b0;
    logic [NK-1:0] key_in = '1;
    logic [NK-1:0] key_press, key_release, key_long, key_state;
    logic          key_any;
    logic [NK-1:0] ah_in = '0;
    logic [NK-1:0] ah_press, ah_release, ah_long, ah_state;
    logic          ah_any;

    int compared = 0;
    int mismatched = 0;
    int press_cnt[NK];
    int rel_cnt[NK];
    int long_cnt[NK];

    always #5 Clk = ~Clk;

    key_filter_multi #(
        .NUM_KEYS(NK), .DEB_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8), .CNT_W(8), .ACTIVE_LOW(1)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .key_in(key_in),
        .key_press(key_press), .key_release(key_release), .key_long(key_long),
        .key_state(key_state), .key_any(key_any)
    );

    key_filter_multi #(
        .NUM_KEYS(NK), .DEB_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8), .CNT_W(8), .ACTIVE_LOW(0)
    ) dut_ah (
        .Clk(Clk), .Rst_n(Rst_n), .key_in(ah_in),
        .key_press(ah_press), .key_release(ah_release), .key_long(ah_long),
        .key_state(ah_state), .key_any(ah_any)
    );

    initial begin
        for (int i = 0; i < NK; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
            long_cnt[i]  = 0;
        end
    end

    always @(negedge Clk) begin
        if (Rst_n) begin
            for (int i = 0; i < NK; i++) begin
                press_cnt[i] += int'(key_press[i]);
                rel_cnt[i]   += int'(key_release[i]);
                long_cnt[i]  += int'(key_long[i]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        step(2);
        check("rst_state", 32'(key_state), 32'hF);
        check("rst_press", 32'(key_press), 32'h0);
        check("rst_release", 32'(key_release), 32'h0);
        check("rst_long", 32'(key_long), 32'h0);
        check("rst_any", 32'(key_any), 32'h0);
        check("rst_ah_state", 32'(ah_state), 32'hF);
        Rst_n = 1'b1;
        step(2);

        // Clean press / release on key 0
        key_in[0] = 1'b0;
        step(6);
        check("p0_early_press", 32'(key_press), 32'h0);
        check("p0_early_state", 32'(key_state), 32'hF);
        step(1);
        check("p0_press", 32'(key_press), 32'h1);
        check("p0_state", 32'(key_state), 32'hE);
        check("p0_any", 32'(key_any), 32'h1);
        step(1);
        check("p0_press_1cyc", 32'(key_press), 32'h0);
        step(2);
        key_in[0] = 1'b1;
        step(6);
        check("r0_early_release", 32'(key_release), 32'h0);
        check("r0_early_state", 32'(key_state), 32'hE);
        step(1);
        check("r0_release", 32'(key_release), 32'h1);
        check("r0_state", 32'(key_state), 32'hF);
        check("r0_any", 32'(key_any), 32'h0);
        step(1);
        check("r0_release_1cyc", 32'(key_release), 32'h0);

        // Press glitches on key 1
        key_in[1] = 1'b0;
        step(3);
        key_in[1] = 1'b1;
        step(10);
        check("g1_short_state", 32'(key_state), 32'hF);
        check("g1_short_cnt", 32'(press_cnt[1]), 32'd0);
        key_in[1] = 1'b0;
        step(2);
        key_in[1] = 1'b1;
        step(1);
        key_in[1] = 1'b0;
        step(1);
        key_in[1] = 1'b1;
        step(10);
        check("g1_mid_state", 32'(key_state), 32'hF);
        check("g1_mid_cnt", 32'(press_cnt[1]), 32'd0);

        // Release bounce on key 2
        key_in[2] = 1'b0;
        step(8);
        check("b2_pressed", 32'(key_state), 32'hB);
        key_in[2] = 1'b1;
        step(2);
        key_in[2] = 1'b0;
        step(10);
        check("b2_no_release", 32'(rel_cnt[2]), 32'd0);
        check("b2_state", 32'(key_state), 32'hB);
        key_in[2] = 1'b1;
        step(10);
        check("b2_released", 32'(key_state), 32'hF);
        check("b2_release_cnt", 32'(rel_cnt[2]), 32'd1);

        // Long press on key 3
        key_in[3] = 1'b0;
        step(7);
        check("l3_press", 32'(key_press), 32'h8);
        step(19);
        check("l3_long_early", 32'(key_long), 32'h0);
        step(1);
        check("l3_long", 32'(key_long), 32'h8);
        step(1);
        check("l3_long_1cyc", 32'(key_long), 32'h0);
        step(7);
        check("l3_at28", 32'(key_long), 32'(EXP_LONG_AT28));
        step(32);
        key_in[3] = 1'b1;
        step(8);
        check("l3_long_cnt", 32'(long_cnt[3]), 32'(EXP_LONG3_CNT));
        check("l3_released", 32'(key_state), 32'hF);

        // Simultaneous press / release on keys 0 and 1
        key_in[1:0] = 2'b00;
        step(7);
        check("s01_press", 32'(key_press), 32'h3);
        check("s01_state", 32'(key_state), 32'hC);
        step(1);
        key_in[1:0] = 2'b11;
        step(7);
        check("s01_release", 32'(key_release), 32'h3);
        step(1);

        // Reset during FILTER0, key 0 held through reset release
        key_in[0] = 1'b0;
        step(4);
        Rst_n = 1'b0;
        step(1);
        check("rf_state", 32'(key_state), 32'hF);
        check("rf_press", 32'(key_press), 32'h0);
        check("rf_any", 32'(key_any), 32'h0);
        step(2);
        Rst_n = 1'b1;
        step(6);
        check("rh_early_press", 32'(key_press), 32'h0);
        step(1);
        check("rh_press", 32'(key_press), 32'h1);
        check("rh_state", 32'(key_state), 32'hE);
        step(1);
        key_in[0] = 1'b1;
        step(8);

        // Active-high instance
        ah_in[0] = 1'b1;
        step(6);
        check("ah_early_press", 32'(ah_press), 32'h0);
        step(1);
        check("ah_press", 32'(ah_press), 32'h1);
        check("ah_state", 32'(ah_state), 32'hE);
        check("ah_any", 32'(ah_any), 32'h1);
        step(2);

        // Totals
        check("tot_press0", 32'(press_cnt[0]), 32'd3);
        check("tot_rel0", 32'(rel_cnt[0]), 32'd3);
        check("tot_press1", 32'(press_cnt[1]), 32'd1);
        check("tot_long0", 32'(long_cnt[0]), 32'd0);
        check("tot_long2", 32'(long_cnt[2]), 32'd0);
        check("tot_state", 32'(key_state), 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
